// File: rtl/mmio_fifo_bank_pkg.sv
// Shared constants and types for the MMIO FIFO bank AFU: CCI-P subset,
// DFH/AFU_ID values, channel address map and register bit positions.
package mmio_fifo_bank_pkg;

    // CCI-P subset seen by this AFU
    typedef struct packed {
        logic [15:0] address;   // 32-bit-word MMIO address
        logic [1:0]  length;
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        logic [27:0]  hdr;
        logic [511:0] data;
        logic         rspValid;
        logic         mmioRdValid;
        logic         mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [27:0] hdr;
        logic        rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [73:0] hdr;
        logic        valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        logic [79:0]  hdr;
        logic [511:0] data;
        logic         valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    // Device feature header: type AFU, end of list, no next DFH, rev 0, id 0
    localparam logic [3:0]  DFH_TYPE_AFU = 4'h1;
    localparam logic        DFH_EOL      = 1'b1;
    localparam logic [63:0] DFH_WORD     = {DFH_TYPE_AFU, 19'b0, DFH_EOL, 24'b0, 4'b0, 12'b0};
    localparam logic [63:0] AFU_ID_L     = 64'hb4a1_1c9f_6e2d_0f35;
    localparam logic [63:0] AFU_ID_H     = 64'h7e1d_4c2a_93f0_45b8;

    localparam logic [15:0] ADDR_DFH  = 16'h0000;
    localparam logic [15:0] ADDR_ID_L = 16'h0002;
    localparam logic [15:0] ADDR_ID_H = 16'h0004;

    // Channel window
    localparam logic [15:0] CH_BASE   = 16'h0020;
    localparam logic [15:0] CH_STRIDE = 16'd8;
    localparam logic [2:0]  OFS_DATA   = 3'd0;
    localparam logic [2:0]  OFS_STATUS = 3'd2;
    localparam logic [2:0]  OFS_CTRL   = 3'd4;

    // STATUS / CTRL bit positions
    localparam int STAT_EMPTY = 16;
    localparam int STAT_FULL  = 17;
    localparam int STAT_OVF   = 18;
    localparam int STAT_UNF   = 19;
    localparam int CTRL_FLUSH = 0;
    localparam int CTRL_CLR   = 1;

endpackage

// File: rtl/mmio_fifo_bank_sync_fifo.sv
// Show-ahead synchronous FIFO. Pop on empty and push on full are ignored,
// except that a push on full is accepted when a pop frees a slot in the same
// cycle. Flush overrides push and pop.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_fifo_bank.sv
// CCI-P AFU exposing NUM_CH independent 64-bit FIFOs over MMIO. Writes push,
// reads pop; per-channel STATUS with sticky overflow/underflow and CTRL for
// flush / flag clear. Read responses return on c2 exactly one cycle later.
module mmio_fifo_bank
    import mmio_fifo_bank_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  t_if_ccip_Rx rx,
    output t_if_ccip_Tx tx
);
    localparam int CNT_W = $clog2(DEPTH+1);

    t_ccip_c0_ReqMmioHdr hdr;
    logic                wr;
    logic                rd;
    logic [15:0]         rel;
    logic [15:0]         slot;
    logic [2:0]          ofs;
    logic                in_ch;

    logic [NUM_CH-1:0] ch_hit, push, pop, flush, clr;
    logic [NUM_CH-1:0] full, empty, ovf, unf;
    logic [63:0]       dout [NUM_CH];
    logic [CNT_W-1:0]  cnt  [NUM_CH];

    logic [63:0]       rdata;
    t_if_ccip_c2_Tx    c2_q;

    assign hdr   = t_ccip_c0_ReqMmioHdr'(rx.c0.hdr);
    assign wr    = rx.c0.mmioWrValid;
    assign rd    = rx.c0.mmioRdValid;
    assign in_ch = (hdr.address >= CH_BASE);
    assign rel   = hdr.address - CH_BASE;
    assign slot  = rel / CH_STRIDE;
    assign ofs   = 3'(rel % CH_STRIDE);

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : gen_ch
            logic ovf_q;
            logic unf_q;

            assign ch_hit[g] = in_ch && (slot == 16'(g));
            assign push[g]   = wr & ch_hit[g] & (ofs == OFS_DATA);
            assign pop[g]    = rd & ch_hit[g] & (ofs == OFS_DATA);
            assign flush[g]  = wr & ch_hit[g] & (ofs == OFS_CTRL) & rx.c0.data[CTRL_FLUSH];
            assign clr[g]    = wr & ch_hit[g] & (ofs == OFS_CTRL) & rx.c0.data[CTRL_CLR];
            assign ovf[g]    = ovf_q;
            assign unf[g]    = unf_q;

            sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (push[g]),
                .pop   (pop[g]),
                .flush (flush[g]),
                .din   (rx.c0.data[63:0]),
                .dout  (dout[g]),
                .count (cnt[g]),
                .full  (full[g]),
                .empty (empty[g])
            );

            // Sticky flags: a push on full is not an overflow if a pop frees a slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                    unf_q <= 1'b0;
                end else begin
                    ovf_q <= (ovf_q & ~clr[g]) | (push[g] & full[g] & ~pop[g]);
                    unf_q <= (unf_q & ~clr[g]) | (pop[g] & empty[g]);
                end
            end
        end
    endgenerate

    // Read data mux from pre-edge state; unmapped addresses return 0
    always_comb begin
        rdata = '0;
        if (!in_ch) begin
            case (hdr.address)
                ADDR_DFH:  rdata = DFH_WORD;
                ADDR_ID_L: rdata = AFU_ID_L;
                ADDR_ID_H: rdata = AFU_ID_H;
                default:   rdata = '0;
            endcase
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_hit[i]) begin
                    case (ofs)
                        OFS_DATA:   rdata = empty[i] ? '0 : dout[i];
                        OFS_STATUS: begin
                            rdata[15:0]       = 16'(cnt[i]);
                            rdata[STAT_EMPTY] = empty[i];
                            rdata[STAT_FULL]  = full[i];
                            rdata[STAT_OVF]   = ovf[i];
                            rdata[STAT_UNF]   = unf[i];
                        end
                        default:    rdata = '0;
                    endcase
                end
            end
        end
    end

    // c2 response register: one-cycle pulse per read, data/tid hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c2_q <= '0;
        end else begin
            c2_q.mmioRdValid <= rd;
            if (rd) begin
                c2_q.hdr.tid <= hdr.tid;
                c2_q.data    <= rdata;
            end
        end
    end

    assign tx.c0 = '0;
    assign tx.c1 = '0;
    assign tx.c2 = c2_q;

    logic unused_rx_bits;
    assign unused_rx_bits = ^{rx.c0.data[511:64], rx.c0.rspValid, rx.c1,
                              rx.c0TxAlmFull, rx.c1TxAlmFull, hdr.length, hdr.rsvd};

endmodule

// File: tb/tb_mmio_fifo_bank.sv
// Bench for mmio_fifo_bank: queue-based reference model of the register map,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mmio_fifo_bank;
    import mmio_fifo_bank_pkg::*;

    localparam int NCH = 4;
    localparam int DEP = 16;
    localparam logic [63:0] M_DFH  = 64'h1000_0100_0000_0000;
    localparam logic [63:0] M_ID_L = 64'hb4a1_1c9f_6e2d_0f35;
    localparam logic [63:0] M_ID_H = 64'h7e1d_4c2a_93f0_45b8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    t_if_ccip_Rx rx;
    t_if_ccip_Tx tx;

    always #5 clk = ~clk;

    mmio_fifo_bank #(.NUM_CH(NCH), .DEPTH(DEP)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .tx  (tx)
    );

    // Reference model state
    logic [63:0] mq [NCH][$];
    bit          movf [NCH];
    bit          munf [NCH];

    // Expectation for the response to the request presented this cycle
    logic        nxt_vld = 1'b0;
    logic [8:0]  nxt_tid = '0;
    logic [63:0] nxt_data = '0;
    logic        nxt_pin = 1'b0;
    logic [63:0] nxt_pin_val = '0;
    int          nxt_pin_id = 0;

    logic        exp_vld;
    logic [8:0]  exp_tid;
    logic [63:0] exp_data;
    logic        exp_pin;
    logic [63:0] exp_pin_val;
    int          exp_pin_id;

    int total = 0;
    int bad = 0;

    function automatic int ch_of(input logic [15:0] a);
        int c;
        if (a < 16'h0020) return -1;
        c = (int'(a) - 32) / 8;
        return (c < NCH) ? c : -1;
    endfunction

    function automatic logic [63:0] model_rd(input logic [15:0] a);
        int c;
        int o;
        logic [63:0] v;
        v = 64'h0;
        if (a == 16'h0000) v = M_DFH;
        else if (a == 16'h0002) v = M_ID_L;
        else if (a == 16'h0004) v = M_ID_H;
        c = ch_of(a);
        if (c >= 0) begin
            o = (int'(a) - 32) % 8;
            if (o == 0) begin
                if (mq[c].size() != 0) v = mq[c][0];
            end else if (o == 2) begin
                v = 64'(mq[c].size());
                if (mq[c].size() == 0)   v = v | 64'h1_0000;
                if (mq[c].size() == DEP) v = v | 64'h2_0000;
                if (movf[c])             v = v | 64'h4_0000;
                if (munf[c])             v = v | 64'h8_0000;
            end
        end
        return v;
    endfunction

    task automatic model_update(input bit wr, input bit rd, input logic [15:0] a,
                                input logic [63:0] wd);
        int c;
        int o;
        c = ch_of(a);
        if (c < 0) return;
        o = (int'(a) - 32) % 8;
        if (wr && o == 4 && wd[1]) begin
            movf[c] = 1'b0;
            munf[c] = 1'b0;
        end
        if (rd && o == 0) begin
            if (mq[c].size() == 0) munf[c] = 1'b1;
            else void'(mq[c].pop_front());
        end
        if (wr && o == 0) begin
            if (mq[c].size() < DEP) mq[c].push_back(wd);
            else movf[c] = 1'b1;
        end
        if (wr && o == 4 && wd[0]) mq[c].delete();
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            movf[c] = 1'b0;
            munf[c] = 1'b0;
        end
    endtask

    // One bus cycle: drive request at negedge, predict response, advance model
    task automatic cyc(input bit wr, input bit rd, input logic [15:0] a,
                       input logic [63:0] wd, input bit pin = 1'b0,
                       input logic [63:0] pv = 64'h0, input int pid = 0);
        t_ccip_c0_ReqMmioHdr h;
        @(negedge clk);
        h         = '0;
        h.address = a;
        h.tid     = 9'($urandom);
        h.length  = 2'($urandom);
        rx        = '0;
        for (int k = 0; k < 16; k++) rx.c0.data[k*32 +: 32] = $urandom();
        rx.c0.data[63:0]  = wd;
        rx.c0.hdr         = h;
        rx.c0.mmioWrValid = wr;
        rx.c0.mmioRdValid = rd;
        rx.c1.hdr         = 28'($urandom);
        nxt_vld     = rd;
        nxt_tid     = h.tid;
        nxt_data    = rd ? model_rd(a) : 64'h0;
        nxt_pin     = pin && rd;
        nxt_pin_val = pv;
        nxt_pin_id  = pid;
        model_update(wr, rd, a, wd);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 16'h0, 64'h0);
    endtask

    // Response expected one cycle after each request; data holds between reads
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_vld     <= 1'b0;
            exp_tid     <= '0;
            exp_data    <= '0;
            exp_pin     <= 1'b0;
            exp_pin_val <= '0;
            exp_pin_id  <= 0;
        end else begin
            exp_vld <= nxt_vld;
            if (nxt_vld) begin
                exp_tid  <= nxt_tid;
                exp_data <= nxt_data;
            end
            exp_pin     <= nxt_pin;
            exp_pin_val <= nxt_pin_val;
            exp_pin_id  <= nxt_pin_id;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, want);
        end
    endtask

    // Compare process, away from the active edge
    always @(negedge clk) begin
        chk("rd_valid", 64'(tx.c2.mmioRdValid), 64'(exp_vld));
        if (exp_vld) chk("rd_tid", 64'(tx.c2.hdr.tid), 64'(exp_tid));
        chk("rd_data", tx.c2.data, exp_data);
        chk("c0c1_idle", 64'(|{tx.c0, tx.c1}), 64'h0);
        if (exp_pin) begin
            total++;
            if (tx.c2.data !== exp_pin_val) begin
                bad++;
                $display("FAIL pin%0d @%0t: got %h want %h", exp_pin_id, $time,
                         tx.c2.data, exp_pin_val);
            end
        end
    end

    initial begin
        int r;
        int c;
        logic [15:0] base;

        rx = '0;
        model_reset();
        #1 rst = 1'b1;
        repeat (3) idle();
        rst = 1'b0;

        // Reset state and DFH / AFU_ID
        cyc(0, 1, 16'h0022, 0, 1, 64'h1_0000, 1);
        cyc(0, 1, 16'h0000, 0, 1, 64'h1000_0100_0000_0000, 2);
        cyc(0, 1, 16'h0002, 0, 1, 64'hb4a1_1c9f_6e2d_0f35, 3);
        cyc(0, 1, 16'h0004, 0, 1, 64'h7e1d_4c2a_93f0_45b8, 4);
        cyc(0, 1, 16'h0006, 0, 1, 64'h0, 5);

        // Single-channel order
        cyc(1, 0, 16'h0020, 64'hA);
        cyc(1, 0, 16'h0020, 64'hB);
        cyc(1, 0, 16'h0020, 64'hC);
        cyc(0, 1, 16'h0022, 0, 1, 64'h3, 10);
        cyc(0, 1, 16'h0020, 0, 1, 64'hA, 11);
        cyc(0, 1, 16'h0020, 0, 1, 64'hB, 12);
        cyc(0, 1, 16'h0020, 0, 1, 64'hC, 13);
        cyc(0, 1, 16'h0022, 0, 1, 64'h1_0000, 14);

        // Overflow on ch1
        for (int i = 1; i <= 17; i++) cyc(1, 0, 16'h0028, 64'(i));
        cyc(0, 1, 16'h002A, 0, 1, 64'h6_0010, 20);
        for (int i = 1; i <= 16; i++) cyc(0, 1, 16'h0028, 0, 1, 64'(i), 100 + i);
        cyc(0, 1, 16'h002A, 0, 1, 64'h5_0000, 21);
        cyc(1, 0, 16'h002C, 64'h2);

        // Underflow and clear on ch2
        cyc(0, 1, 16'h0030, 0, 1, 64'h0, 30);
        cyc(0, 1, 16'h0032, 0, 1, 64'h9_0000, 31);
        cyc(1, 0, 16'h0034, 64'h2);
        cyc(0, 1, 16'h0032, 0, 1, 64'h1_0000, 32);
        cyc(0, 1, 16'h0034, 0, 1, 64'h0, 33);
        cyc(0, 1, 16'h0036, 0, 1, 64'h0, 34);

        // Flush and isolation
        for (int i = 0; i < 5; i++) cyc(1, 0, 16'h0020, 64'h100 + 64'(i));
        cyc(1, 0, 16'h0038, 64'h300);
        cyc(1, 0, 16'h0038, 64'h301);
        cyc(1, 0, 16'h0024, 64'h1);
        cyc(0, 1, 16'h0022, 0, 1, 64'h1_0000, 40);
        cyc(0, 1, 16'h003A, 0, 1, 64'h2, 41);
        cyc(0, 1, 16'h0038, 0, 1, 64'h300, 42);
        cyc(0, 1, 16'h0038, 0, 1, 64'h301, 43);
        cyc(1, 0, 16'h0040, 64'hDEAD);
        cyc(0, 1, 16'h0042, 0, 1, 64'h0, 44);

        // Coincident write+read on ch2: full then empty
        for (int i = 0; i < 16; i++) cyc(1, 0, 16'h0030, 64'h200 + 64'(i));
        cyc(1, 1, 16'h0030, 64'h2AA, 1, 64'h200, 50);
        cyc(0, 1, 16'h0032, 0, 1, 64'h2_0010, 51);
        cyc(1, 0, 16'h0034, 64'h3);
        cyc(1, 1, 16'h0030, 64'h55, 1, 64'h0, 52);
        cyc(0, 1, 16'h0032, 0, 1, 64'h8_0001, 53);
        cyc(0, 1, 16'h0030, 0, 1, 64'h55, 54);
        cyc(1, 0, 16'h0034, 64'h2);

        // Wrap-around on ch0
        for (int i = 0; i < 40; i++) begin
            cyc(1, 0, 16'h0020, 64'h1000 + 64'(i));
            if (i >= 2) cyc(0, 1, 16'h0020, 0, 1, 64'h1000 + 64'(i - 2), 300 + i);
        end
        cyc(0, 1, 16'h0020, 0, 1, 64'h1026, 60);
        cyc(0, 1, 16'h0020, 0, 1, 64'h1027, 61);

        // Mid-operation reset with 3 entries queued and a response on the bus
        for (int i = 0; i < 3; i++) cyc(1, 0, 16'h0020, 64'h77 + 64'(i));
        cyc(0, 1, 16'h0022, 0, 1, 64'h3, 62);
        idle();
        #2 rst = 1'b1;
        model_reset();
        repeat (3) idle();
        rst = 1'b0;
        cyc(0, 1, 16'h0022, 0, 1, 64'h1_0000, 70);
        cyc(0, 1, 16'h002A, 0, 1, 64'h1_0000, 71);
        cyc(0, 1, 16'h0032, 0, 1, 64'h1_0000, 72);
        cyc(0, 1, 16'h003A, 0, 1, 64'h1_0000, 73);
        cyc(0, 1, 16'h0020, 0, 1, 64'h0, 74);

        // Randomized traffic, including the unmapped slot 4 and stray addresses
        for (int n = 0; n < 3000; n++) begin
            r    = $urandom_range(0, 99);
            c    = $urandom_range(0, 4);
            base = 16'h0020 + 16'(8 * c);
            if (r < 44)      cyc(1, 0, base, {$urandom(), $urandom()});
            else if (r < 78) cyc(0, 1, base, 0);
            else if (r < 88) cyc(0, 1, base + 16'd2, 0);
            else if (r < 91) cyc(1, 0, base + 16'd4, 64'($urandom_range(0, 3)));
            else if (r < 94) cyc(0, 1, base + 16'($urandom_range(1, 7)), 0);
            else if (r < 96) cyc(0, 1, 16'($urandom_range(0, 15)), 0);
            else if (r < 98) cyc(1, 0, 16'($urandom_range(0, 71)), {$urandom(), $urandom()});
            else             idle();
        end

        repeat (3) idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_fifo_bank.md
# mmio_fifo_bank

CCI-P AFU that exposes `NUM_CH` independent 64-bit FIFOs to the host through MMIO, with per-channel status and control registers. It is the parametrised successor to the single-register MMIO FIFO AFU: host MMIO writes push, host MMIO reads pop, and overflow/underflow are recorded instead of silently corrupting state. It sits directly behind the registered CCI-P shim and generates no host-memory traffic.

## Interface
- `NUM_CH`, default 4: number of FIFO channels, 1..8.
- `DEPTH`, default 16: entries per FIFO; a power of two, ≥2.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `rx` input `t_if_ccip_Rx`: CCI-P receive. Only `c0.mmioWrValid`, `c0.mmioRdValid`, `c0.hdr` (cast to `t_ccip_c0_ReqMmioHdr`) and `c0.data[63:0]` are used.
- `tx` output `t_if_ccip_Tx`: CCI-P transmit. Only `c2` is driven; `c0`/`c1` are held at 0.

## Operation
- The address map uses 32-bit-word MMIO addresses. Every register is 64 bits on an even address.
- `0x0000`: DFH, with feature type AFU and end-of-list set. `0x0002`/`0x0004`: AFU_ID low/high. `0x0006`/`0x0008`: 0.
- Channel i has base `B = 0x0020 + 8*i`:
  - `B+0` DATA: a write pushes `data[63:0]`; a read pops the head entry and returns it.
  - `B+2` STATUS (read-only): bits [15:0] = count, zero-extended; bit16 = empty; bit17 = full; bit18 = overflow (sticky); bit19 = underflow (sticky); all other bits 0.
  - `B+4` CTRL (write-only; reads return 0): bit0 = 1 flushes the FIFO; bit1 = 1 clears both sticky flags. Both bits may be set together.
- Push when full: the data is dropped, pointers and count are unchanged, and overflow is set.
- Pop when empty: the response data is 0, nothing changes, and underflow is set.
- Flush:
  - Pointers and count go to 0.
  - Sticky flags are unchanged unless bit1 is also set.
  - Flush takes precedence over any push on the same channel in the same cycle.
- Unmapped addresses, including channel slots ≥ `NUM_CH` and `B+6`:
  - Writes are ignored.
  - Reads return 0 and still produce a response.
- Pointer width is `$clog2(DEPTH)` and pointers wrap modulo `DEPTH`. Count width is `$clog2(DEPTH+1)`, so count equals `DEPTH` when the FIFO is full.
- If `mmioWrValid` and `mmioRdValid` coincide (CCI-P forbids this; the block tolerates it):
  - Both actions are performed.
  - The read response reflects the pre-write state.
  - On the same channel, push and pop occur together and count is unchanged. If the FIFO was full, the push is not an overflow because the pop frees a slot. If the FIFO was empty, the pop underflows and the push is still accepted.
- Reset:
  - All FIFOs are empty, counts are 0, and sticky flags are 0.
  - `tx` is all zero, including `c2.mmioRdValid` = 0, `c2.hdr` = 0 and `c2.data` = 0.
  - RAM contents are not reset.
- Reset asserted mid-operation discards all queued data and any pending response.

## Timing
- Read latency is exactly 1 cycle: `rx.c0.mmioRdValid` in cycle N produces `tx.c2.mmioRdValid` = 1 in cycle N+1 for one cycle, with `tx.c2.hdr.tid` copied from the request.
- Back-to-back reads produce back-to-back responses; no request is ever stalled or dropped.
- The FIFO is show-ahead: the head entry is readable combinationally and registered into `tx.c2.data`. The pop pointer and count update at the same edge.
- A push in cycle N is visible to a DATA read or a STATUS read issued in cycle N+1.
- The sticky flags set at the edge that ends the offending request cycle.
- `tx.c2.data` holds its last value while `mmioRdValid` = 0.

## Structure
- Package `mmio_fifo_bank_pkg` holds:
  - DFH field constants and `CH_BASE` = `0x0020`, `CH_STRIDE` = 8.
  - Register offsets `OFS_DATA` = 0, `OFS_STATUS` = 2, `OFS_CTRL` = 4.
  - STATUS bit positions and CTRL bit positions.
- Sub-module `sync_fifo` (parameters `WIDTH`, `DEPTH`) is instantiated `NUM_CH` times in a generate loop.
  - Ports: `push`, `pop`, `flush`, `din`, `dout`, `count`, `full`, `empty`.
  - It ignores a pop when empty and a push when full, unless a pop occurs in the same cycle.
- The top level performs address decode, maintains the sticky flags, and owns the c2 response register.

## Test plan
- **Reset then DFH reads.** Read `0x0000`, `0x0002`, `0x0004` → responses arrive exactly 1 cycle after each request, each with its matching tid. The data is the DFH word and the UUID halves.
- **Single-channel FIFO order.** Write 0xA, 0xB, 0xC to ch0 DATA (`0x0020`). STATUS (`0x0022`) reads count = 3. Three DATA reads return 0xA, 0xB, 0xC in order. STATUS then reads empty = 1.
- **Overflow.** With `DEPTH` = 16, push 17 values to ch1 (`0x0028`). STATUS reads count = 16, full = 1, overflow = 1. Popping 16 times returns values 1..16; the 17th value was dropped.
- **Underflow and clear.** Read empty ch2 DATA (`0x0030`) → data 0 and underflow = 1. Write 2 to CTRL (`0x0034`) → STATUS reads 0x10000 (empty only).
- **Flush and channel isolation.** Push 5 values to ch0 and 2 values to ch3. Write 1 to ch0 CTRL → ch0 count = 0, ch3 count = 2, and the ch3 data is intact.
- **Wrap-around and mid-operation reset.** Push and pop 40 values on ch0 with `DEPTH` = 16 → data order is preserved. Assert `rst` with 3 entries queued → all STATUS registers read 0x10000 and `tx` is 0 during reset.
